// File: rtl/seven_segment_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
package seven_segment_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] AN_OFF = 4'hF;
    localparam logic [7:0] CA_OFF = 8'hFF;

    typedef logic [1:0] digit_t;

    typedef enum logic [1:0] {
        BLANKING,
        DRIVING,
        DARK
    } scan_state_e;

endpackage

// File: rtl/seven_segment_scanner.sv
// Scans four latched cathode patterns onto a common-anode display with
// per-slot blanking, frame-coherent latching and 8-level PWM brightness.
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] segments [NUM_DIGITS],
    input  logic [2:0] brightness,
    output logic [3:0] an,
    output logic [7:0] ca,
    output logic       frame_start,
    output logic [1:0] scan_state
);

    localparam int CW    = $clog2(DIGIT_CYCLES);
    localparam int PW    = CW + 4;
    localparam int DRIVE = DIGIT_CYCLES - BLANK_CYCLES;

    localparam logic [CW-1:0] LAST_COUNT = CW'(DIGIT_CYCLES - 1);
    localparam digit_t        LAST_DIGIT = digit_t'(NUM_DIGITS - 1);

    logic [CW-1:0] count;
    digit_t        digit;
    scan_state_e   state;
    logic [7:0]    shadow [NUM_DIGITS];
    logic [2:0]    bright;

    logic [PW-1:0] cnt_ext;
    logic [PW-1:0] on_cycles;
    scan_state_e   slot_state;
    logic [3:0]    an_d;
    logic [7:0]    ca_d;
    logic          frame_d;
    logic          last_cycle;

    // (bright+1)*DRIVE fits in CW+3 bits; the shift happens after the full product.
    always_comb begin
        cnt_ext   = PW'(count);
        on_cycles = ((PW'(bright) + PW'(1)) * PW'(DRIVE)) >> 3;
        if (cnt_ext < PW'(BLANK_CYCLES)) begin
            slot_state = BLANKING;
        end else if (cnt_ext < PW'(BLANK_CYCLES) + on_cycles) begin
            slot_state = DRIVING;
        end else begin
            slot_state = DARK;
        end
    end

    always_comb begin
        an_d = AN_OFF;
        ca_d = CA_OFF;
        if (slot_state == DRIVING) begin
            an_d = ~(4'b0001 << digit);
            ca_d = shadow[digit];
        end
    end

    assign frame_d    = (digit == '0) && (count == '0);
    assign last_cycle = (count == LAST_COUNT);

    // Output flops are loaded from the decode of the slot cycle held in
    // count/digit, so the very first cycle after reset presents slot 0 of
    // digit 0 and shadow/bright always change on a frame boundary.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count       <= '0;
            digit       <= '0;
            state       <= BLANKING;
            shadow      <= '{default: CA_OFF};
            bright      <= 3'd7;
            an          <= AN_OFF;
            ca          <= CA_OFF;
            frame_start <= 1'b0;
        end else begin
            state       <= slot_state;
            an          <= an_d;
            ca          <= ca_d;
            frame_start <= frame_d;
            if (last_cycle) begin
                count <= '0;
                digit <= digit + 1'b1;
                if (digit == LAST_DIGIT) begin
                    shadow <= segments;
                    bright <= brightness;
                end
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign scan_state = state;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner with a cycle-level reference
// model feeding an expected-output queue.
module tb_seven_segment_scanner;

    localparam int DIGIT_CYCLES = 16;
    localparam int BLANK_CYCLES = 4;
    localparam int FRAME        = 4 * DIGIT_CYCLES;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] segments [4];
    logic [2:0] brightness;
    logic [3:0] an;
    logic [7:0] ca;
    logic       frame_start;
    logic [1:0] scan_state;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    int          m_n;
    logic [7:0]  m_shadow [4];
    logic [2:0]  m_bright;
    logic [12:0] exp_q[$];

    seven_segment_scanner #(
        .DIGIT_CYCLES(DIGIT_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .segments   (segments),
        .brightness (brightness),
        .an         (an),
        .ca         (ca),
        .frame_start(frame_start),
        .scan_state (scan_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // reference model: m_n is the index of the slot cycle shown after this edge
    always @(posedge clk or negedge resetn) begin
        int d, s, on;
        logic [3:0] e_an;
        logic [7:0] e_ca;
        if (!resetn) begin
            m_n      = 0;
            m_shadow = '{default: 8'hFF};
            m_bright = 3'd7;
            exp_q.delete();
        end else begin
            d    = (m_n / DIGIT_CYCLES) % 4;
            s    = m_n % DIGIT_CYCLES;
            on   = ((int'(m_bright) + 1) * (DIGIT_CYCLES - BLANK_CYCLES)) / 8;
            e_an = 4'hF;
            e_ca = 8'hFF;
            if (s >= BLANK_CYCLES && s < BLANK_CYCLES + on) begin
                e_an[d] = 1'b0;
                e_ca    = m_shadow[d];
            end
            exp_q.push_back({e_an, e_ca, (m_n % FRAME) == 0});
            if (m_n % FRAME == FRAME - 1) begin
                m_shadow = segments;
                m_bright = brightness;
            end
            m_n++;
        end
    end

    // scoreboard
    always @(negedge clk) begin
        logic [12:0] e;
        if (resetn === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({an, ca, frame_start} !== e) begin
                errors++;
                $display("FAIL scoreboard cycle %0d: got an=%b ca=%h fs=%b, expected an=%b ca=%h fs=%b",
                         cycle, an, ca, frame_start, e[12:9], e[8:1], e[0]);
            end
        end
    end

    task automatic test_reset();
        #3 resetn = 1'b0;
        #1;
        checks++;
        if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %b want %b", an, 4'hF); end
        checks++;
        if (ca !== 8'hFF) begin errors++; $display("FAIL reset_ca got %h want %h", ca, 8'hFF); end
        checks++;
        if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
        checks++;
        if (scan_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", scan_state); end
        @(negedge clk);
        #2 resetn = 1'b1;
    endtask

    task automatic test_dark_first_frame();
        int lit = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (frame_start !== 1'b1) begin errors++; $display("FAIL first_frame_start got %b want 1", frame_start); end
            end
            if (ca !== 8'hFF) lit++;
        end
        checks++;
        if (lit != 0) begin errors++; $display("FAIL first_frame_dark lit cycles %0d want 0", lit); end
    endtask

    task automatic test_slot_and_tearing();
        int n, f, s, d;
        int d1_lit = 0, d1_first = -1, f1_d2_old = 0, f2_d2_new = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            n = m_n - 1;
            f = n / FRAME;
            s = n % DIGIT_CYCLES;
            d = (n / DIGIT_CYCLES) % 4;
            if (f == 1 && d == 1 && an === 4'b1101 && ca === 8'hF9) begin
                if (d1_first < 0) d1_first = s;
                d1_lit++;
            end
            if (f == 1 && d == 2 && an === 4'b1011 && ca === 8'hA4) f1_d2_old++;
            if (f == 2 && d == 2 && an === 4'b1011 && ca === 8'h99) f2_d2_new++;
            if (n == FRAME + DIGIT_CYCLES) segments[2] = 8'h99;
        end
        checks++;
        if (d1_lit != 12) begin errors++; $display("FAIL digit1_lit got %0d want 12", d1_lit); end
        checks++;
        if (d1_first != 4) begin errors++; $display("FAIL digit1_first_lit got %0d want 4", d1_first); end
        checks++;
        if (f1_d2_old != 12) begin errors++; $display("FAIL no_tear_old got %0d want 12", f1_d2_old); end
        checks++;
        if (f2_d2_new != 12) begin errors++; $display("FAIL next_frame_new got %0d want 12", f2_d2_new); end
    endtask

    task automatic test_brightness(input logic [2:0] b, input int want_on, input string name);
        int f0, n_end, n, off = 0;
        int lit [4] = '{0, 0, 0, 0};
        brightness = b;
        f0    = m_n / FRAME;
        n_end = (f0 + 2) * FRAME - 1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            n = m_n - 1;
            if (n / FRAME == f0 + 1) begin
                for (int dd = 0; dd < 4; dd++) if (an === ~(4'b0001 << dd)) lit[dd]++;
                if (an === 4'hF) off++;
            end
            if (n >= n_end) break;
        end
        for (int dd = 0; dd < 4; dd++) begin
            checks++;
            if (lit[dd] != want_on) begin
                errors++; $display("FAIL %s_lit_digit%0d got %0d want %0d", name, dd, lit[dd], want_on);
            end
        end
        checks++;
        if (off != FRAME - 4 * want_on) begin
            errors++; $display("FAIL %s_off_cycles got %0d want %0d", name, off, FRAME - 4 * want_on);
        end
    endtask

    task automatic test_frame_start();
        int pulses[$];
        for (int i = 0; i < 3 * FRAME + 1; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                pulses.push_back(cycle);
                checks++;
                if (an !== 4'hF) begin errors++; $display("FAIL frame_start_blank an %b want 1111", an); end
            end
        end
        checks++;
        if (pulses.size() < 3) begin errors++; $display("FAIL frame_start_count got %0d want >=3", pulses.size()); end
        for (int i = 1; i < pulses.size(); i++) begin
            checks++;
            if (pulses[i] - pulses[i-1] != FRAME) begin
                errors++; $display("FAIL frame_start_period got %0d want %0d", pulses[i] - pulses[i-1], FRAME);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] prev_an = 4'hF;
        int blank_run = BLANK_CYCLES;
        int change_at;
        for (int fr = 0; fr < 1000; fr++) begin
            change_at = $urandom_range(0, FRAME - 1);
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                checks++;
                if ($countones(~an) > 1) begin errors++; $display("FAIL anode_onehot an %b want at most one low", an); end
                if (an !== 4'hF && prev_an === 4'hF) begin
                    checks++;
                    if (blank_run < BLANK_CYCLES) begin
                        errors++; $display("FAIL anode_dead_time got %0d want >=%0d", blank_run, BLANK_CYCLES);
                    end
                end
                blank_run = (an === 4'hF) ? blank_run + 1 : 0;
                prev_an   = an;
                if (i == change_at) begin
                    for (int dd = 0; dd < 4; dd++) segments[dd] = 8'($urandom_range(0, 255));
                    brightness = 3'($urandom_range(0, 7));
                end
            end
        end
    endtask

    task automatic test_reset_mid_drive();
        int found = 0, lit = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (an !== 4'hF) begin found = 1; break; end
        end
        checks++;
        if (found == 0) begin errors++; $display("FAIL find_drive_cycle got none want one within %0d", FRAME); end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (an !== 4'hF) begin errors++; $display("FAIL midreset_an got %b want 1111", an); end
        checks++;
        if (ca !== 8'hFF) begin errors++; $display("FAIL midreset_ca got %h want ff", ca); end
        @(negedge clk);
        #2 resetn = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (frame_start !== 1'b1) begin errors++; $display("FAIL restart_frame_start got %b want 1", frame_start); end
            end
            if (ca !== 8'hFF) lit++;
        end
        checks++;
        if (lit != 0) begin errors++; $display("FAIL restart_dark lit cycles %0d want 0", lit); end
    endtask

    initial begin
        resetn     = 1'b1;
        segments   = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
        brightness = 3'd7;
        test_reset();
        test_dark_first_frame();
        test_slot_and_tearing();
        test_brightness(3'd3, 6, "bright3");
        test_brightness(3'd0, 1, "bright0");
        test_frame_start();
        test_random();
        test_reset_mid_drive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
